// File: rtl/free_list_pkg.sv
// -----------------------------------------------------------------------------
// free_list_pkg
// Shared definitions for the rename-stage physical register free list and its
// neighbours (dispatch, RAT write port).
//   - Sizing constants: physical/architectural register counts, rename width,
//     free-list depth, tag width and the wrap-bit pointer width.
//   - FL_ALLOC_OUTPACKET: {tag, valid} packet describing one granted tag.
//   - popcount2: population count of a 2-bit slot mask.
// -----------------------------------------------------------------------------
package free_list_pkg;

  localparam int NUM_PREGS      = 64;
  localparam int NUM_AREGS      = 32;
  localparam int SCALAR         = 2;
  localparam int FL_DEPTH       = NUM_PREGS - NUM_AREGS;
  localparam int PREG_IDX_WIDTH = $clog2(NUM_PREGS);
  localparam int FL_IDX_WIDTH   = $clog2(FL_DEPTH);
  // One extra MSB on every pointer acts as the wrap bit, so full and empty
  // are distinguishable when the low index bits match.
  localparam int FL_PTR_WIDTH   = FL_IDX_WIDTH + 1;

  typedef struct packed {
    logic [PREG_IDX_WIDTH-1:0] tag;
    logic                      valid;
  } FL_ALLOC_OUTPACKET;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/free_list.sv
// -----------------------------------------------------------------------------
// free_list
// Physical-register free list for the 2-way rename stage. Hands out new tags
// to the RAT, takes back the superseded tag (T_old) of each retiring
// instruction, and restores all speculative allocations on rollback.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high; highest priority
//   rollback     mispredict recovery (retire cycle of the branch)
//   alloc_req    per-slot rename request
//   alloc_ok     every requested tag granted this cycle (low = stall)
//   alloc_tag    granted tag per slot, 0 for non-requesting slots
//   retire_en    per-slot retire of an instruction with a destination
//   retire_told  per-slot superseded tag returned to the list
//   free_count   registered number of tags in the list
//
// Configuration macro: FREE_LIST_BYPASS_EN
//   defined   -> tags retiring this cycle may be allocated in the same cycle
//   undefined -> retiring tags become allocatable on the next cycle
// -----------------------------------------------------------------------------
module free_list
  import free_list_pkg::*;
(
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  rollback,
  input  logic [SCALAR-1:0]                     alloc_req,
  output logic                                  alloc_ok,
  output logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0] alloc_tag,
  input  logic [SCALAR-1:0]                     retire_en,
  input  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0] retire_told,
  output logic [FL_PTR_WIDTH-1:0]               free_count
);

  logic [PREG_IDX_WIDTH-1:0] tag_buf [FL_DEPTH];

  logic [FL_PTR_WIDTH-1:0] head;
  logic [FL_PTR_WIDTH-1:0] arch_head;
  logic [FL_PTR_WIDTH-1:0] tail;
  logic [FL_PTR_WIDTH-1:0] count;

  logic [FL_PTR_WIDTH-1:0] head_next;
  logic [FL_PTR_WIDTH-1:0] arch_head_next;
  logic [FL_PTR_WIDTH-1:0] tail_next;

  logic [1:0]              n_req;
  logic [1:0]              n_ret;
  logic [FL_PTR_WIDTH:0]   avail;

  logic [FL_IDX_WIDTH-1:0] rd_idx0;
  logic [FL_IDX_WIDTH-1:0] rd_idx1;
  logic [FL_IDX_WIDTH-1:0] wr_idx0;
  logic [FL_IDX_WIDTH-1:0] wr_idx1;

  logic [PREG_IDX_WIDTH-1:0] ret_list [SCALAR];
  logic [PREG_IDX_WIDTH-1:0] pos_tag  [SCALAR];

  FL_ALLOC_OUTPACKET alloc_pkt [SCALAR];

  assign count      = tail - head;
  assign free_count = count;
  assign n_req      = popcount2(alloc_req);
  assign n_ret      = popcount2(retire_en);

  assign rd_idx0 = head[FL_IDX_WIDTH-1:0];
  assign rd_idx1 = rd_idx0 + FL_IDX_WIDTH'(1);
  assign wr_idx0 = tail[FL_IDX_WIDTH-1:0];
  assign wr_idx1 = wr_idx0 + FL_IDX_WIDTH'(1);

  // Retiring tags compacted in slot order: position 0 is the first retiring
  // slot, position 1 is only meaningful when both slots retire.
  always_comb begin
    ret_list[0] = retire_en[0] ? retire_told[0] : retire_told[1];
    ret_list[1] = retire_told[1];
  end

  // Tag available at allocation position p. With bypass, positions beyond the
  // registered count come from the tags retiring this cycle; those tags are
  // also written at tail, so the pointer arithmetic matches the plain case.
  always_comb begin
    pos_tag[0] = tag_buf[rd_idx0];
    pos_tag[1] = tag_buf[rd_idx1];
    avail      = {1'b0, count};
`ifdef FREE_LIST_BYPASS_EN
    avail = {1'b0, count} + {{(FL_PTR_WIDTH-1){1'b0}}, n_ret};
    if (count == '0) begin
      pos_tag[0] = ret_list[0];
      pos_tag[1] = ret_list[1];
    end else if (count == FL_PTR_WIDTH'(1)) begin
      pos_tag[1] = ret_list[0];
    end
`endif
  end

  // All-or-nothing grant; rollback squashes this cycle's renames entirely.
  assign alloc_ok = !rollback && (avail >= {{(FL_PTR_WIDTH-1){1'b0}}, n_req});

  // Requesting slots are compacted: slot 1 takes position 0 when slot 0 is idle.
  always_comb begin
    alloc_pkt[0].valid = alloc_req[0];
    alloc_pkt[0].tag   = pos_tag[0];
    alloc_pkt[1].valid = alloc_req[1];
    alloc_pkt[1].tag   = alloc_req[0] ? pos_tag[1] : pos_tag[0];
    for (int i = 0; i < SCALAR; i++) begin
      alloc_tag[i] = alloc_pkt[i].valid ? alloc_pkt[i].tag : '0;
    end
  end

  // Every retiring destination consumed one tag in program order, so the
  // committed read pointer advances in step with the write pointer. Rollback
  // rewinds the speculative pointer to the committed one, including this
  // cycle's retirements.
  always_comb begin
    tail_next      = tail + {{(FL_PTR_WIDTH-2){1'b0}}, n_ret};
    arch_head_next = arch_head + {{(FL_PTR_WIDTH-2){1'b0}}, n_ret};
    head_next      = head;
    if (rollback) begin
      head_next = arch_head_next;
    end else if (alloc_ok) begin
      head_next = head + {{(FL_PTR_WIDTH-2){1'b0}}, n_req};
    end
  end

  // Pointer and buffer update; reset seeds the list with the pregs that are
  // not part of the architectural reset mapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        tag_buf[i] <= PREG_IDX_WIDTH'(NUM_AREGS + i);
      end
      head      <= '0;
      arch_head <= '0;
      tail      <= FL_PTR_WIDTH'(FL_DEPTH);
    end else begin
      if (retire_en[0]) begin
        tag_buf[wr_idx0] <= retire_told[0];
      end
      if (retire_en[1]) begin
        tag_buf[retire_en[0] ? wr_idx1 : wr_idx0] <= retire_told[1];
      end
      head      <= head_next;
      arch_head <= arch_head_next;
      tail      <= tail_next;
    end
  end

`ifndef SYNTHESIS
  logic [FL_PTR_WIDTH-1:0] occ_next;
  logic [FL_PTR_WIDTH-1:0] spec_next;
  logic [FL_PTR_WIDTH-1:0] span_next;

  assign occ_next  = tail_next - head_next;
  assign spec_next = head_next - arch_head_next;
  assign span_next = tail_next - arch_head_next;

  // Overflow, head passing tail, and arch_head passing head all show up as
  // an out-of-range modular distance between the pointers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (occ_next <= FL_PTR_WIDTH'(FL_DEPTH));
      assert (spec_next <= span_next);
      assert (spec_next <= FL_PTR_WIDTH'(FL_DEPTH));
    end
  end
`endif

endmodule

// File: tb/tb_free_list.sv
// -----------------------------------------------------------------------------
// tb_free_list
// Directed self-checking bench for free_list: reset image, batch allocation,
// drain to empty, refill and buffer wrap, rollback recovery, partial-grant
// refusal (with the bypass variant when FREE_LIST_BYPASS_EN is defined) and
// reset in the middle of a rollback.
// -----------------------------------------------------------------------------
module tb_free_list;
  import free_list_pkg::*;

  logic                                  clock = 1'b0;
  logic                                  reset;
  logic                                  rollback;
  logic [SCALAR-1:0]                     alloc_req;
  logic                                  alloc_ok;
  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0] alloc_tag;
  logic [SCALAR-1:0]                     retire_en;
  logic [SCALAR-1:0][PREG_IDX_WIDTH-1:0] retire_told;
  logic [FL_PTR_WIDTH-1:0]               free_count;

  int checks   = 0;
  int failures = 0;

  logic [PREG_IDX_WIDTH-1:0] model_q [$];
  logic [PREG_IDX_WIDTH-1:0] exp0;
  logic [PREG_IDX_WIDTH-1:0] exp1;

  free_list dut (
    .clock       (clock),
    .reset       (reset),
    .rollback    (rollback),
    .alloc_req   (alloc_req),
    .alloc_ok    (alloc_ok),
    .alloc_tag   (alloc_tag),
    .retire_en   (retire_en),
    .retire_told (retire_told),
    .free_count  (free_count)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive all inputs, then let combinational outputs settle.
  task automatic apply_stimulus(input logic rst, input logic rb,
                                input logic [1:0] req, input logic [1:0] ret,
                                input int told0, input int told1);
    reset          = rst;
    rollback       = rb;
    alloc_req      = req;
    retire_en      = ret;
    retire_told[0] = PREG_IDX_WIDTH'(told0);
    retire_told[1] = PREG_IDX_WIDTH'(told1);
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
  endtask

  initial begin
    apply_stimulus(1'b1, 1'b0, 2'b00, 2'b00, 0, 0);
    tick();
    tick();

    // Reset image and batch allocation
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("rst_count", 32'(free_count), 32);
    check_output("rst_ok", 32'(alloc_ok), 1);
    check_output("rst_tag0", 32'(alloc_tag[0]), 32);
    check_output("rst_tag1", 32'(alloc_tag[1]), 33);
    tick();
    check_output("t1_tag0_b", 32'(alloc_tag[0]), 34);
    check_output("t1_tag1_b", 32'(alloc_tag[1]), 35);
    check_output("t1_count_b", 32'(free_count), 30);
    tick();
    check_output("t1_tag0_c", 32'(alloc_tag[0]), 36);
    check_output("t1_tag1_c", 32'(alloc_tag[1]), 37);
    check_output("t1_count_c", 32'(free_count), 28);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
    check_output("t1_count_end", 32'(free_count), 26);

    // Drain to empty
    do_reset();
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      check_output("drain_ok", 32'(alloc_ok), 1);
      check_output("drain_tag0", 32'(alloc_tag[0]), 32 + 2 * k);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
    check_output("empty_count", 32'(free_count), 0);
    check_output("empty_noreq_ok", 32'(alloc_ok), 1);
    apply_stimulus(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
    check_output("empty_req_ok", 32'(alloc_ok), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
    check_output("empty_hold_count", 32'(free_count), 0);

    // Refill from empty, then stream through the buffer wrap
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b11, 5, 9);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("refill_count", 32'(free_count), 2);
    check_output("refill_ok", 32'(alloc_ok), 1);
    check_output("refill_tag0", 32'(alloc_tag[0]), 5);
    check_output("refill_tag1", 32'(alloc_tag[1]), 9);
    tick();
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b0, 1'b0, 2'b00, 2'b11, 10 + 2 * k, 11 + 2 * k);
      model_q.push_back(PREG_IDX_WIDTH'(10 + 2 * k));
      model_q.push_back(PREG_IDX_WIDTH'(11 + 2 * k));
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, 1'b0, 2'b11, 2'b11, 14 + 2 * i, 15 + 2 * i);
      check_output("wrap_count", 32'(free_count), model_q.size());
      exp0 = model_q.pop_front();
      exp1 = model_q.pop_front();
      check_output("wrap_ok", 32'(alloc_ok), 1);
      check_output("wrap_tag0", 32'(alloc_tag[0]), 32'(exp0));
      check_output("wrap_tag1", 32'(alloc_tag[1]), 32'(exp1));
      model_q.push_back(PREG_IDX_WIDTH'(14 + 2 * i));
      model_q.push_back(PREG_IDX_WIDTH'(15 + 2 * i));
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      exp0 = model_q.pop_front();
      exp1 = model_q.pop_front();
      check_output("tailend_tag0", 32'(alloc_tag[0]), 32'(exp0));
      check_output("tailend_tag1", 32'(alloc_tag[1]), 32'(exp1));
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
    check_output("wrap_end_count", 32'(free_count), 0);

    // Slot compaction: lone request on slot 1 takes the head tag
    do_reset();
    apply_stimulus(1'b0, 1'b0, 2'b10, 2'b00, 0, 0);
    check_output("compact_tag0", 32'(alloc_tag[0]), 0);
    check_output("compact_tag1", 32'(alloc_tag[1]), 32);

    // Rollback restores speculative tags in order
    do_reset();
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b11, 3, 4);
    tick();
    apply_stimulus(1'b0, 1'b1, 2'b11, 2'b01, 7, 0);
    check_output("rb_ok", 32'(alloc_ok), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("rb_count", 32'(free_count), 32);
    check_output("rb_tag0", 32'(alloc_tag[0]), 35);
    check_output("rb_tag1", 32'(alloc_tag[1]), 36);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
    check_output("rb_tag2", 32'(alloc_tag[0]), 37);
    tick();
    apply_stimulus(1'b0, 1'b1, 2'b11, 2'b00, 0, 0);

    // Reset while rollback is high
    apply_stimulus(1'b1, 1'b1, 2'b11, 2'b01, 20, 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("midrst_count", 32'(free_count), 32);
    check_output("midrst_ok", 32'(alloc_ok), 1);
    check_output("midrst_tag0", 32'(alloc_tag[0]), 32);
    check_output("midrst_tag1", 32'(alloc_tag[1]), 33);

    // Partial grant refused with a single tag left
    do_reset();
    for (int k = 0; k < 15; k++) begin
      apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 2'b01, 2'b00, 0, 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("one_count", 32'(free_count), 1);
    check_output("one_ok", 32'(alloc_ok), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b01, 50, 0);
    check_output("one_hold_count", 32'(free_count), 1);
`ifdef FREE_LIST_BYPASS_EN
    check_output("bypass_ok", 32'(alloc_ok), 1);
    check_output("bypass_tag0", 32'(alloc_tag[0]), 63);
    check_output("bypass_tag1", 32'(alloc_tag[1]), 50);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b00, 2'b00, 0, 0);
    check_output("bypass_count", 32'(free_count), 0);
`else
    check_output("nobypass_ok", 32'(alloc_ok), 0);
    tick();
    apply_stimulus(1'b0, 1'b0, 2'b11, 2'b00, 0, 0);
    check_output("nobypass_count", 32'(free_count), 2);
    check_output("nobypass_tag0", 32'(alloc_tag[0]), 63);
    check_output("nobypass_tag1", 32'(alloc_tag[1]), 50);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
